// File: rtl/sonar_pkg.sv
// -----------------------------------------------------------------------------
// sonar_pkg
// Shared definitions for the sonar serial transmitter:
//   - estado_t       : top-level FSM state encoding (codes visible on db_estado)
//   - uart_estado_t  : state encoding of the character UART
//   - ASCII_*        : characters used to build the "AAA,DDD#" frame
//   - NUM_CHARS      : characters per frame
//   - digito_ascii() : BCD nibble to ASCII digit, '?' for non-decimal nibbles
//   - paridade_impar(): odd-parity bit over a 7-bit ASCII code
// -----------------------------------------------------------------------------
package sonar_pkg;

  typedef enum logic [3:0] {
    ST_OCIOSO      = 4'd0,
    ST_CARREGA     = 4'd1,
    ST_ENVIA       = 4'd2,
    ST_ESPERA_CHAR = 4'd3,
    ST_PROXIMO     = 4'd4,
    ST_FINAL       = 4'd5
  } estado_t;

  typedef enum logic [1:0] {
    UART_OCIOSO = 2'd0,
    UART_CARGA  = 2'd1,
    UART_BITS   = 2'd2
  } uart_estado_t;

  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_VIRGULA = 8'h2C;
  localparam logic [7:0] ASCII_HASH    = 8'h23;
  localparam logic [7:0] ASCII_ERRO    = 8'h3F;

  localparam int NUM_CHARS = 8;
  localparam logic [2:0] ULTIMO_INDICE = 3'(NUM_CHARS - 1);

  // Bits on the line per character: start + 8 payload bits + stop.
  localparam logic [3:0] ULTIMO_BIT = 4'd9;

  function automatic logic [7:0] digito_ascii(input logic [3:0] nibble);
    logic [7:0] c;
    if (nibble > 4'd9) begin
      c = ASCII_ERRO;
    end else begin
      c = ASCII_ZERO + {4'd0, nibble};
    end
    return c;
  endfunction

  // Odd parity: data plus parity bit carry an odd number of ones.
  function automatic logic paridade_impar(input logic [6:0] dado);
    return ~(^dado);
  endfunction

endpackage

// File: rtl/sonar_tx_uart.sv
// -----------------------------------------------------------------------------
// sonar_tx_uart
// Single-character asynchronous transmitter: start bit (0), 8 payload bits
// LSB first, stop bit (1); every bit lasts DIV clock cycles.
// Build option SONAR_TX_PARITY_EN: payload is ASCII[6:0] followed by an
// odd-parity bit instead of the full 8-bit code (still 10 bits per character).
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous, active-high
//   partida      in   one-cycle request to send dado (accepted when idle)
//   dado[7:0]    in   character to send, sampled together with partida
//   saida_serial out  TX line, idle high (registered)
//   pronto       out  character-done indication (see note on timing below)
//
// Latency: partida sampled on edge N -> start bit on the line after edge N+1.
// -----------------------------------------------------------------------------
module sonar_tx_uart
  import sonar_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic [7:0] dado,
  output logic       saida_serial,
  output logic       pronto
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BAUD_ULTIMO    = CW'(DIV - 1);
  localparam logic [CW-1:0] BAUD_PENULTIMO = CW'(DIV - 2);

  uart_estado_t  estado_r, estado_n;
  logic [9:0]    shift_r, shift_n;
  logic [CW-1:0] baud_r, baud_n;
  logic [3:0]    bit_r, bit_n;
  logic          linha_r, linha_n;
  logic [9:0]    quadro;
  logic          pronto_s;

  // Assemble the 10-bit line frame {stop, payload, start}.
  always_comb begin
    quadro = {1'b1, dado, 1'b0};
`ifdef SONAR_TX_PARITY_EN
    quadro = {1'b1, paridade_impar(dado[6:0]), dado[6:0], 1'b0};
`else
    quadro = {1'b1, dado, 1'b0};
`endif
  end

  // Next-state logic: idle -> load -> shift out 10 bits of DIV cycles each.
  // Done is flagged one cycle before the stop bit ends so that the caller's
  // per-character bookkeeping overlaps the tail of the stop bit.
  always_comb begin
    estado_n = estado_r;
    shift_n  = shift_r;
    baud_n   = baud_r;
    bit_n    = bit_r;
    linha_n  = linha_r;
    pronto_s = 1'b0;
    case (estado_r)
      UART_OCIOSO: begin
        linha_n = 1'b1;
        if (partida) begin
          shift_n  = quadro;
          estado_n = UART_CARGA;
        end else begin
          estado_n = UART_OCIOSO;
        end
      end
      UART_CARGA: begin
        linha_n  = shift_r[0];
        shift_n  = {1'b1, shift_r[9:1]};
        baud_n   = {CW{1'b0}};
        bit_n    = 4'd0;
        estado_n = UART_BITS;
      end
      UART_BITS: begin
        if ((bit_r == ULTIMO_BIT) && (baud_r == BAUD_PENULTIMO)) begin
          pronto_s = 1'b1;
        end else begin
          pronto_s = 1'b0;
        end
        if (baud_r == BAUD_ULTIMO) begin
          baud_n = {CW{1'b0}};
          if (bit_r == ULTIMO_BIT) begin
            linha_n  = 1'b1;
            estado_n = UART_OCIOSO;
          end else begin
            linha_n = shift_r[0];
            shift_n = {1'b1, shift_r[9:1]};
            bit_n   = bit_r + 4'd1;
          end
        end else begin
          baud_n = baud_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        linha_n  = 1'b1;
        estado_n = UART_OCIOSO;
      end
    endcase
  end

  // State, counters, shift register and line register.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_r <= UART_OCIOSO;
      shift_r  <= 10'h3FF;
      baud_r   <= {CW{1'b0}};
      bit_r    <= 4'd0;
      linha_r  <= 1'b1;
    end else begin
      estado_r <= estado_n;
      shift_r  <= shift_n;
      baud_r   <= baud_n;
      bit_r    <= bit_n;
      linha_r  <= linha_n;
    end
  end

  assign saida_serial = linha_r;
  assign pronto       = pronto_s;

endmodule

// File: rtl/sonar_transmissor.sv
// -----------------------------------------------------------------------------
// sonar_transmissor
// On partida (in ocioso) snapshots angulo/distancia (3 BCD digits each) and
// transmits the ASCII frame "AAA,DDD#" over sonar_tx_uart, then pulses pronto.
// Build option SONAR_TX_PARITY_EN selects 7 data bits + odd parity in the UART.
//
// Parameters: CLK_FREQ (Hz), BAUD (bit/s); DIV = CLK_FREQ/BAUD, DIV >= 2.
// Ports:
//   clock             in   system clock, rising edge
//   reset             in   synchronous, active-high
//   partida           in   start request, honoured only in ocioso
//   angulo[11:0]      in   BCD hundreds/tens/units
//   distancia[11:0]   in   BCD hundreds/tens/units
//   saida_serial      out  TX line, idle high
//   ocupado           out  busy, from the cycle after accepted partida to pronto
//   pronto            out  one-cycle frame-finished pulse
//   db_estado[3:0]    out  current FSM state code
//   db_caractere[7:0] out  character currently loaded for transmission
//
// Each character slot is 10*DIV+3 cycles: 3 FSM overhead cycles
// (proximo/carrega/envia) overlap the last stop-bit cycle and UART load.
// -----------------------------------------------------------------------------
module sonar_transmissor
  import sonar_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        partida,
  input  logic [11:0] angulo,
  input  logic [11:0] distancia,
  output logic        saida_serial,
  output logic        ocupado,
  output logic        pronto,
  output logic [3:0]  db_estado,
  output logic [7:0]  db_caractere
);

  localparam int DIV = CLK_FREQ / BAUD;

  estado_t     estado_r, estado_n;
  logic [11:0] angulo_r, distancia_r;
  logic [2:0]  indice_r;
  logic [7:0]  caractere_r;
  logic        pronto_r, ocupado_r;

  logic        captura_s, carrega_s, inicia_uart_s, avanca_s;
  logic [7:0]  caractere_sel_s;
  logic        uart_pronto_s;
  logic        uart_linha_s;

  // Character selection for the current index from the snapshot registers.
  always_comb begin
    caractere_sel_s = ASCII_HASH;
    case (indice_r)
      3'd0:    caractere_sel_s = digito_ascii(angulo_r[11:8]);
      3'd1:    caractere_sel_s = digito_ascii(angulo_r[7:4]);
      3'd2:    caractere_sel_s = digito_ascii(angulo_r[3:0]);
      3'd3:    caractere_sel_s = ASCII_VIRGULA;
      3'd4:    caractere_sel_s = digito_ascii(distancia_r[11:8]);
      3'd5:    caractere_sel_s = digito_ascii(distancia_r[7:4]);
      3'd6:    caractere_sel_s = digito_ascii(distancia_r[3:0]);
      3'd7:    caractere_sel_s = ASCII_HASH;
      default: caractere_sel_s = ASCII_HASH;
    endcase
  end

  // Frame FSM next-state and control strobes.
  always_comb begin
    estado_n      = estado_r;
    captura_s     = 1'b0;
    carrega_s     = 1'b0;
    inicia_uart_s = 1'b0;
    avanca_s      = 1'b0;
    case (estado_r)
      ST_OCIOSO: begin
        if (partida) begin
          captura_s = 1'b1;
          estado_n  = ST_CARREGA;
        end else begin
          estado_n  = ST_OCIOSO;
        end
      end
      ST_CARREGA: begin
        carrega_s = 1'b1;
        estado_n  = ST_ENVIA;
      end
      ST_ENVIA: begin
        inicia_uart_s = 1'b1;
        estado_n      = ST_ESPERA_CHAR;
      end
      ST_ESPERA_CHAR: begin
        if (uart_pronto_s) begin
          estado_n = ST_PROXIMO;
        end else begin
          estado_n = ST_ESPERA_CHAR;
        end
      end
      ST_PROXIMO: begin
        if (indice_r == ULTIMO_INDICE) begin
          estado_n = ST_FINAL;
        end else begin
          avanca_s = 1'b1;
          estado_n = ST_CARREGA;
        end
      end
      ST_FINAL: begin
        estado_n = ST_OCIOSO;
      end
      default: begin
        estado_n = ST_OCIOSO;
      end
    endcase
  end

  // State register, input snapshot, character index and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_r    <= ST_OCIOSO;
      angulo_r    <= 12'h000;
      distancia_r <= 12'h000;
      indice_r    <= 3'd0;
      caractere_r <= 8'h00;
      pronto_r    <= 1'b0;
      ocupado_r   <= 1'b0;
    end else begin
      estado_r <= estado_n;
      if (captura_s) begin
        angulo_r    <= angulo;
        distancia_r <= distancia;
        indice_r    <= 3'd0;
      end else if (avanca_s) begin
        indice_r <= indice_r + 3'd1;
      end else begin
        indice_r <= indice_r;
      end
      if (carrega_s) begin
        caractere_r <= caractere_sel_s;
      end else begin
        caractere_r <= caractere_r;
      end
      pronto_r  <= (estado_r == ST_FINAL);
      // Busy stays up through the pronto cycle that follows ST_FINAL.
      ocupado_r <= (estado_n != ST_OCIOSO) || (estado_r == ST_FINAL);
    end
  end

  sonar_tx_uart #(
    .DIV (DIV)
  ) u_uart (
    .clock        (clock),
    .reset        (reset),
    .partida      (inicia_uart_s),
    .dado         (caractere_r),
    .saida_serial (uart_linha_s),
    .pronto       (uart_pronto_s)
  );

  assign saida_serial = uart_linha_s;
  assign ocupado      = ocupado_r;
  assign pronto       = pronto_r;
  assign db_estado    = estado_r;
  assign db_caractere = caractere_r;

endmodule

// File: tb/tb_sonar_transmissor.sv
// -----------------------------------------------------------------------------
// tb_sonar_transmissor
// Directed + randomized bench for sonar_transmissor with CLK_FREQ=1000,
// BAUD=100 (DIV=10). Expected line waveform, busy/done timing and decoded
// characters come from a cycle-position model of the frame format.
// -----------------------------------------------------------------------------
module tb_sonar_transmissor;

  localparam int DIV  = 10;
  localparam int SLOT = 10 * DIV + 3;
  localparam int NCYC = 8 * SLOT + 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        partida;
  logic [11:0] angulo;
  logic [11:0] distancia;
  logic        saida_serial;
  logic        ocupado;
  logic        pronto;
  logic [3:0]  db_estado;
  logic [7:0]  db_caractere;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_chars [0:7];
  logic       linha_cap [0:NCYC];

  sonar_transmissor #(
    .CLK_FREQ (1000),
    .BAUD     (100)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .partida      (partida),
    .angulo       (angulo),
    .distancia    (distancia),
    .saida_serial (saida_serial),
    .ocupado      (ocupado),
    .pronto       (pronto),
    .db_estado    (db_estado),
    .db_caractere (db_caractere)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] asc(input logic [3:0] n);
    if (n > 4'd9) return 8'h3F;
    return 8'h30 + {4'h0, n};
  endfunction

  function automatic logic [7:0] char_of(input int k, input logic [11:0] a, input logic [11:0] d);
    case (k)
      0: return asc(a[11:8]);
      1: return asc(a[7:4]);
      2: return asc(a[3:0]);
      3: return 8'h2C;
      4: return asc(d[11:8]);
      5: return asc(d[7:4]);
      6: return asc(d[3:0]);
      default: return 8'h23;
    endcase
  endfunction

  // 8 payload bits as they appear on the line (LSB first).
  function automatic logic [7:0] wire_byte(input logic [7:0] c);
`ifdef SONAR_TX_PARITY_EN
    return {~(^c[6:0]), c[6:0]};
`else
    return c;
`endif
  endfunction

  // Expected line level in the cycle after edge n (edge 0 samples partida).
  function automatic logic exp_line(input int n);
    int off, k, o, b;
    logic [7:0] w;
    if (n < 3) return 1'b1;
    off = n - 3;
    k = off / SLOT;
    o = off % SLOT;
    if (k >= 8 || o >= 10 * DIV) return 1'b1;
    b = o / DIV;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    w = wire_byte(exp_chars[k]);
    return w[b-1];
  endfunction

  task automatic run_frame(input logic [11:0] a, input logic [11:0] d,
                           input bit mexe, input bit repete);
    int pr_count, pr_pos, lin_err, lin_first, ocp_err, chr_err, stop_err, idx;
    logic [7:0] b;
    logic [7:0] got [$];
    pr_count = 0; pr_pos = -1; lin_err = 0; lin_first = -1;
    ocp_err = 0; chr_err = 0; stop_err = 0;
    for (int k = 0; k < 8; k++) exp_chars[k] = char_of(k, a, d);

    @(negedge clock);
    angulo = a; distancia = d; partida = 1'b1;
    @(posedge clock); #1;
    partida = 1'b0;
    linha_cap[0] = saida_serial;
    check("estado_after_edge0", 32'(db_estado), 32'd1);
    check("ocupado_after_edge0", 32'(ocupado), 32'd1);

    for (int n = 1; n <= NCYC; n++) begin
      @(posedge clock); #1;
      linha_cap[n] = saida_serial;
      if (saida_serial !== exp_line(n)) begin
        if (lin_err == 0) lin_first = n;
        lin_err++;
      end
      if (pronto === 1'b1) begin
        pr_count++;
        pr_pos = n;
      end else if (pronto !== 1'b0) begin
        pr_count += 100;
      end
      if (ocupado !== ((n <= NCYC - 1) ? 1'b1 : 1'b0)) ocp_err++;
      if (n == 1) check("estado_after_edge1", 32'(db_estado), 32'd2);
      if (n == 2) check("estado_after_edge2", 32'(db_estado), 32'd3);
      if (n >= 8 && ((n - 8) % SLOT) == 0 && ((n - 8) / SLOT) < 8) begin
        if (db_caractere !== exp_chars[(n - 8) / SLOT]) chr_err++;
      end
      if (mexe) begin
        angulo = 12'($urandom);
        distancia = 12'($urandom);
      end
      partida = (repete && n == 400) ? 1'b1 : 1'b0;
    end
    partida = 1'b0;

    check("line_mismatches", 32'(lin_err), 32'd0);
    if (lin_err != 0) check("first_line_mismatch_cycle", 32'(lin_first), 32'hFFFFFFFF);
    check("ocupado_mismatches", 32'(ocp_err), 32'd0);
    check("pronto_count", 32'(pr_count), 32'd1);
    check("pronto_cycle", 32'(pr_pos), 32'(NCYC - 1));
    check("db_caractere_mismatches", 32'(chr_err), 32'd0);
    check("estado_end", 32'(db_estado), 32'd0);

    // Bench-side UART receiver: find start edges, sample mid-bit.
    idx = 1;
    while (idx <= NCYC) begin
      if (linha_cap[idx] == 1'b0 && linha_cap[idx-1] == 1'b1 &&
          idx + 9 * DIV + DIV / 2 <= NCYC) begin
        for (int j = 0; j < 8; j++) b[j] = linha_cap[idx + (j + 1) * DIV + DIV / 2];
        if (linha_cap[idx + 9 * DIV + DIV / 2] !== 1'b1) stop_err++;
        got.push_back(b);
        idx += 10 * DIV;
      end else begin
        idx++;
      end
    end
    check("decoded_char_count", 32'(got.size()), 32'd8);
    check("stop_bit_errors", 32'(stop_err), 32'd0);
    for (int k = 0; k < 8 && k < got.size(); k++)
      check($sformatf("char%0d", k), 32'(got[k]), 32'(wire_byte(exp_chars[k])));
  endtask

  function automatic logic [11:0] rnd_bcd(input bit allow_bad);
    logic [11:0] v;
    for (int i = 0; i < 3; i++)
      v[i*4 +: 4] = allow_bad ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
    return v;
  endfunction

  initial begin
    int pr_seen;
    reset = 1'b1; partida = 1'b0; angulo = 12'h000; distancia = 12'h000;
    repeat (3) @(posedge clock);
    #1;
    check("reset_line", 32'(saida_serial), 32'd1);
    check("reset_ocupado", 32'(ocupado), 32'd0);
    check("reset_pronto", 32'(pronto), 32'd0);
    check("reset_estado", 32'(db_estado), 32'd0);
    check("reset_caractere", 32'(db_caractere), 32'h00);
    reset = 1'b0;
    repeat (2) @(posedge clock);

    // Basic frame "045,123#".
    run_frame(12'h045, 12'h123, 1'b0, 1'b0);
    // Inputs change during the frame; snapshot must be sent.
    run_frame(12'h178, 12'h090, 1'b1, 1'b0);
    // Invalid nibble -> '?', zeros -> '0'.
    run_frame(12'h000, 12'h1A9, 1'b0, 1'b0);
    // Second partida mid-frame is ignored.
    run_frame(rnd_bcd(1'b0), rnd_bcd(1'b0), 1'b0, 1'b1);

    // Reset during character 3.
    @(negedge clock);
    angulo = 12'h987; distancia = 12'h654; partida = 1'b1;
    @(posedge clock); #1;
    partida = 1'b0;
    repeat (3 * SLOT + 20) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("midreset_line", 32'(saida_serial), 32'd1);
    check("midreset_estado", 32'(db_estado), 32'd0);
    check("midreset_pronto", 32'(pronto), 32'd0);
    check("midreset_ocupado", 32'(ocupado), 32'd0);
    pr_seen = 0;
    for (int i = 0; i < 2 * SLOT; i++) begin
      @(posedge clock); #1;
      if (pronto !== 1'b0 || saida_serial !== 1'b1) pr_seen++;
    end
    check("midreset_quiet_after", 32'(pr_seen), 32'd0);
    run_frame(12'h359, 12'h268, 1'b0, 1'b0);

    // Reset and partida together: reset wins.
    @(negedge clock);
    reset = 1'b1; partida = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; partida = 1'b0;
    check("reset_vs_partida_estado", 32'(db_estado), 32'd0);
    check("reset_vs_partida_ocupado", 32'(ocupado), 32'd0);
    @(posedge clock); #1;
    check("reset_vs_partida_idle", 32'(db_estado), 32'd0);

    // Randomized frames.
    for (int r = 0; r < 3; r++)
      run_frame(rnd_bcd(1'b1), rnd_bcd(r == 1), r == 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
